microcode_sequencer: RTL and testbench
======================================

// Module: microcode_sequencer
// PURPOSE
//   Next-state sequencer for the microprogrammed ARM control unit. Each cycle it picks the next
//   control-state number from one of four sources: increment, the instruction encoder's 7-bit
//   dispatch value, a conditional branch target, or the fetch state.
//   Stalls on memory operations until MFC (memory function complete). Aborts to a trap state on
//   memory timeout. Counts retired instructions.
// PARAMETERS
//   STATE_W      7    width of control-state number
//   FETCH_STATE  1    first state of the instruction-fetch microroutine
//   ABORT_STATE  127  state entered on memory timeout
//   MEM_TIMEOUT  15   max cycles to wait for mfc before abort (must be >=1)
// PORTS
//   clk          in   1        rising-edge clock
//   reset        in   1        synchronous, active-high
//   enc_state    in   STATE_W  dispatch state from instruction encoder
//   ns_sel       in   2        next-state source: 00 inc, 01 encoder dispatch, 10 cond branch, 11 fetch
//   cr_target    in   STATE_W  branch target field of current microinstruction
//   cond_true    in   1        condition-tester result for the current instruction
//   mem_req      in   1        current microinstruction performs a memory access
//   mfc          in   1        memory function complete
//   state        out  STATE_W  current control state (microstore address)
//   stall        out  1        1 while waiting for mfc (state held)
//   mem_err      out  1        one-cycle pulse on the cycle ABORT_STATE is loaded
//   instr_count  out  16       count of entries into FETCH_STATE
// BEHAVIOUR
//   Reset (sync, has priority over everything): state=0, stall=0, mem_err=0, instr_count=0,
//     mode=RUN, wait counter=0. A reset during WAIT discards the pending access.
//   Next-state value nxt is computed combinationally from ns_sel:
//     00: state+1, modulo 2^STATE_W (127 wraps to 0).
//     01: enc_state; if enc_state==0 (null/unrecognised instruction), use FETCH_STATE.
//     10: cond_true ? cr_target : state+1.
//     11: FETCH_STATE.
//   State 0 overrides ns_sel: the cycle after state==0 always loads FETCH_STATE.
//   Modes:
//     RUN, mem_req=0: state<=nxt every cycle (1-cycle latency).
//     RUN, mem_req=1, mfc=1: state<=nxt in the same cycle (zero wait).
//     RUN, mem_req=1, mfc=0: hold state, go to WAIT, cnt<=1, stall=1 from the next cycle.
//     WAIT, mfc=1: state<=nxt, using inputs sampled that cycle; stall<=0, mode<=RUN.
//     WAIT, mfc=0, cnt<MEM_TIMEOUT: hold state, cnt<=cnt+1.
//     WAIT, mfc=0, cnt==MEM_TIMEOUT: state<=ABORT_STATE, mem_err<=1 for one cycle,
//       stall<=0, mode<=RUN.
//     mfc arriving on the timeout cycle wins: normal advance, no error.
//   mem_req is ignored while in WAIT. A stray mfc in RUN without mem_req is ignored.
//   instr_count increments by 1 on every clock edge that loads FETCH_STATE from a different
//     state, including from state 0. It wraps at 2^16. Holding in FETCH_STATE during a stall
//     does not count.
//   All outputs are registered. No combinational path from inputs to outputs.
// TESTING
//   1. Reset held 2 cycles, then released with ns_sel=00: state 0 -> 1 -> 2;
//      instr_count=1 after the first edge.
//   2. state=5, ns_sel=01, enc_state=7'd44: next state=44. With enc_state=0: next state=1.
//   3. ns_sel=10, cr_target=40, cond_true=1 -> 40. cond_true=0 from state 40 -> 41.
//      ns_sel=00 at state 127 -> 0, then -> 1.
//   4. mem_req=1 at state 3, mfc low 4 cycles then high with ns_sel=00: stall=1 for 4 cycles,
//      state stays 3, then advances to 4 with stall=0.
//   5. mem_req=1, mfc never asserted, MEM_TIMEOUT=15: after 15 stall cycles state=127 and
//      mem_err=1 for exactly 1 cycle. Repeat with mfc on cycle 15: no error, normal advance.
//   6. Reset asserted mid-WAIT: next state=0, stall=0, instr_count=0; followed by a clean fetch.

Source files
------------

// File: rtl/microcode_sequencer.sv
// Next-state sequencer for the microprogrammed control unit: selects the next control state,
// stalls on memory accesses until mfc, traps on memory timeout and counts fetched instructions.
module microcode_sequencer #(
   parameter int STATE_W     = 7,
   parameter int FETCH_STATE = 1,
   parameter int ABORT_STATE = 127,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [STATE_W-1:0] enc_state,
   input  logic [1:0]         ns_sel,
   input  logic [STATE_W-1:0] cr_target,
   input  logic               cond_true,
   input  logic               mem_req,
   input  logic               mfc,
   output logic [STATE_W-1:0] state,
   output logic               stall,
   output logic               mem_err,
   output logic [15:0]        instr_count
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [STATE_W-1:0] FETCH   = STATE_W'(FETCH_STATE);
   localparam logic [STATE_W-1:0] ABORT   = STATE_W'(ABORT_STATE);
   localparam logic [CNT_W-1:0]   TIMEOUT = CNT_W'(MEM_TIMEOUT);

   typedef enum logic {
      MODE_RUN,
      MODE_WAIT
   } mode_t;

   mode_t              mode;
   mode_t              mode_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [STATE_W-1:0] inc;
   logic [STATE_W-1:0] nxt;
   logic [STATE_W-1:0] state_nxt;
   logic               advance;
   logic               abort;
   logic               stall_nxt;
   logic               mem_err_nxt;
   logic               count_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         mode        <= MODE_RUN;
         cnt         <= '0;
         state       <= '0;
         stall       <= 1'b0;
         mem_err     <= 1'b0;
         instr_count <= '0;
      end else begin
         mode    <= mode_nxt;
         cnt     <= cnt_nxt;
         state   <= state_nxt;
         stall   <= stall_nxt;
         mem_err <= mem_err_nxt;
         if (count_en) begin
            instr_count <= instr_count + 16'd1;
         end
      end
   end

   // State 0 is the power-up state and always proceeds straight into the fetch routine.
   always_comb begin
      inc = state + STATE_W'(1);
      nxt = inc;
      case (ns_sel)
         2'b00:   nxt = inc;
         2'b01:   nxt = (enc_state == '0) ? FETCH : enc_state;
         2'b10:   nxt = cond_true ? cr_target : inc;
         default: nxt = FETCH;
      endcase
      if (state == '0) begin
         nxt = FETCH;
      end
   end

   always_comb begin
      mode_nxt = mode;
      cnt_nxt  = cnt;
      advance  = 1'b0;
      abort    = 1'b0;
      case (mode)
         MODE_RUN: begin
            if (!mem_req || mfc) begin
               advance = 1'b1;
            end else begin
               mode_nxt = MODE_WAIT;
               cnt_nxt  = CNT_W'(1);
            end
         end
         MODE_WAIT: begin
            // A late mfc on the timeout cycle still completes the access normally.
            if (mfc) begin
               advance  = 1'b1;
               mode_nxt = MODE_RUN;
               cnt_nxt  = '0;
            end else if (cnt == TIMEOUT) begin
               abort    = 1'b1;
               mode_nxt = MODE_RUN;
               cnt_nxt  = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            mode_nxt = MODE_RUN;
            cnt_nxt  = '0;
         end
      endcase
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = ABORT;
      end else if (advance) begin
         state_nxt = nxt;
      end
      stall_nxt   = (mode_nxt == MODE_WAIT);
      mem_err_nxt = abort;
      count_en    = (state_nxt == FETCH) && (state != FETCH);
   end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: an integer-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_microcode_sequencer;

   localparam int STATE_W = 7;
   localparam int FETCH   = 1;
   localparam int ABORT   = 127;
   localparam int TMO     = 15;
   localparam int NSTATES = 1 << STATE_W;

   logic               clk = 1'b0;
   logic               reset;
   logic [STATE_W-1:0] enc_state;
   logic [1:0]         ns_sel;
   logic [STATE_W-1:0] cr_target;
   logic               cond_true;
   logic               mem_req;
   logic               mfc;
   logic [STATE_W-1:0] state;
   logic               stall;
   logic               mem_err;
   logic [15:0]        instr_count;

   int checks_total  = 0;
   int checks_passed = 0;

   int m_state  = 0;
   int m_count  = 0;
   int m_waited = 0;
   bit m_waiting = 1'b0;
   bit m_err     = 1'b0;
   bit m_valid   = 1'b0;

   microcode_sequencer #(
      .STATE_W    (STATE_W),
      .FETCH_STATE(FETCH),
      .ABORT_STATE(ABORT),
      .MEM_TIMEOUT(TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enc_state  (enc_state),
      .ns_sel     (ns_sel),
      .cr_target  (cr_target),
      .cond_true  (cond_true),
      .mem_req    (mem_req),
      .mfc        (mfc),
      .state      (state),
      .stall      (stall),
      .mem_err    (mem_err),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks_total++;
      if (actual == expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int modelTarget();
      int t;
      if (m_state == 0) return FETCH;
      case (ns_sel)
         2'b00:   t = (m_state + 1) % NSTATES;
         2'b01:   t = (int'(enc_state) == 0) ? FETCH : int'(enc_state);
         2'b10:   t = cond_true ? int'(cr_target) : (m_state + 1) % NSTATES;
         default: t = FETCH;
      endcase
      return t;
   endfunction

   function automatic void modelLoad(input int target);
      if (target == FETCH && m_state != FETCH) m_count = (m_count + 1) % 65536;
      m_state = target;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_state   = 0;
         m_count   = 0;
         m_waited  = 0;
         m_waiting = 1'b0;
         m_err     = 1'b0;
         m_valid   = 1'b1;
      end else if (m_valid) begin
         m_err = 1'b0;
         if (!m_waiting) begin
            if (mem_req && !mfc) begin
               m_waiting = 1'b1;
               m_waited  = 1;
            end else begin
               modelLoad(modelTarget());
            end
         end else if (mfc) begin
            modelLoad(modelTarget());
            m_waiting = 1'b0;
         end else if (m_waited >= TMO) begin
            m_state   = ABORT;
            m_err     = 1'b1;
            m_waiting = 1'b0;
         end else begin
            m_waited++;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         checkOutput("model_state", int'(state), m_state);
         checkOutput("model_stall", int'(stall), int'(m_waiting));
         checkOutput("model_mem_err", int'(mem_err), int'(m_err));
         checkOutput("model_instr_count", int'(instr_count), m_count);
      end
   end

   task automatic applyStimulus(input logic r, input logic [1:0] sel, input int enc, input int cr,
                                input logic cond, input logic req, input logic done);
      reset     = r;
      ns_sel    = sel;
      enc_state = STATE_W'(enc);
      cr_target = STATE_W'(cr);
      cond_true = cond;
      mem_req   = req;
      mfc       = done;
      @(posedge clk);
      #1;
   endtask

   task automatic checkDirected(input string tag, input int st, input int stl, input int err,
                                input int cnt);
      checkOutput({tag, "_state"}, int'(state), st);
      checkOutput({tag, "_stall"}, int'(stall), stl);
      checkOutput({tag, "_mem_err"}, int'(mem_err), err);
      checkOutput({tag, "_instr_count"}, int'(instr_count), cnt);
   endtask

   initial begin
      int stall_cycles;
      reset = 1'b1; ns_sel = 2'b00; enc_state = '0; cr_target = '0;
      cond_true = 1'b0; mem_req = 1'b0; mfc = 1'b0;

      applyStimulus(1, 2'b00, 0, 0, 0, 0, 0);
      applyStimulus(1, 2'b00, 0, 0, 0, 0, 0);
      checkDirected("reset", 0, 0, 0, 0);
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
      checkDirected("first_fetch", 1, 0, 0, 1);
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
      checkDirected("inc_to_2", 2, 0, 0, 1);

      for (int i = 0; i < 3; i++) applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
      checkOutput("at_5", int'(state), 5);
      applyStimulus(0, 2'b01, 44, 0, 0, 0, 0);
      checkOutput("dispatch_44", int'(state), 44);
      applyStimulus(0, 2'b01, 0, 0, 0, 0, 0);
      checkDirected("dispatch_null", 1, 0, 0, 2);

      applyStimulus(0, 2'b10, 0, 40, 1, 0, 0);
      checkOutput("branch_taken", int'(state), 40);
      applyStimulus(0, 2'b10, 0, 40, 0, 0, 0);
      checkOutput("branch_not_taken", int'(state), 41);
      applyStimulus(0, 2'b10, 0, 127, 1, 0, 0);
      checkOutput("branch_127", int'(state), 127);
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
      checkOutput("wrap_to_0", int'(state), 0);
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
      checkDirected("zero_to_fetch", 1, 0, 0, 3);
      applyStimulus(0, 2'b11, 0, 0, 0, 0, 0);
      checkDirected("fetch_hold_no_count", 1, 0, 0, 3);
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
      checkOutput("at_3", int'(state), 3);

      stall_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 2'b00, 0, 0, 0, 1, 0);
         if (stall && int'(state) == 3) stall_cycles++;
      end
      checkOutput("short_wait_stall_cycles", stall_cycles, 4);
      applyStimulus(0, 2'b00, 0, 0, 0, 1, 1);
      checkDirected("short_wait_done", 4, 0, 0, 3);
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 1);
      checkOutput("stray_mfc", int'(state), 5);

      stall_cycles = 0;
      for (int i = 0; i < 15; i++) begin
         applyStimulus(0, 2'b00, 0, 0, 0, 1, 0);
         if (stall && int'(state) == 5) stall_cycles++;
      end
      checkOutput("timeout_stall_cycles", stall_cycles, 15);
      applyStimulus(0, 2'b00, 0, 0, 0, 1, 0);
      checkDirected("timeout_abort", 127, 0, 1, 3);
      applyStimulus(0, 2'b11, 0, 0, 0, 0, 0);
      checkDirected("after_abort", 1, 0, 0, 4);

      for (int i = 0; i < 15; i++) applyStimulus(0, 2'b00, 0, 0, 0, 1, 0);
      checkDirected("late_wait", 1, 1, 0, 4);
      applyStimulus(0, 2'b00, 0, 0, 0, 1, 1);
      checkDirected("late_mfc_wins", 2, 0, 0, 4);

      applyStimulus(0, 2'b00, 0, 0, 0, 1, 0);
      applyStimulus(0, 2'b00, 0, 0, 0, 1, 0);
      checkDirected("pre_reset_wait", 2, 1, 0, 4);
      applyStimulus(1, 2'b00, 0, 0, 0, 1, 0);
      checkDirected("reset_mid_wait", 0, 0, 0, 0);
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
      checkDirected("clean_fetch", 1, 0, 0, 1);
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
      checkDirected("clean_inc", 2, 0, 0, 1);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
